// File: rtl/ava_pixel_fifo.sv
// First-word-fall-through pixel buffer between the VRAM read port and the video output stage.
// Raises fifo_busy early, so words still in flight from VRAM always find a free slot.
module ava_pixel_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SLACK      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_last,
    output logic                       fifo_busy,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full      = CntW'(DEPTH);
    localparam logic [CntW-1:0] BusyLevel = CntW'(DEPTH - SLACK);

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic [CntW-1:0]     count_d;
    logic                busy_q;
    logic                busy_d;
    logic                overflow_q;
    logic                push;
    logic                pop;

    always_comb begin
        pop     = (count_q != '0) && rd_ready;
        // When full, a same-cycle pop frees the slot this write needs.
        push    = wr_valid && ((count_q != Full) || pop);
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        busy_d = (count_d >= BusyLevel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            busy_q  <= busy_d;
            if (wr_valid && !push) overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; rd_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end

    assign rd_valid           = (count_q != '0);
    assign {rd_last, rd_data} = mem_q[rd_ptr_q];
    assign level              = count_q;
    assign fifo_busy          = busy_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_ava_pixel_fifo.sv
// Bench for ava_pixel_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_ava_pixel_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SLACK = 2;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          fifo_busy;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [4:0]    level;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {last, data}, sticky overflow flag, busy flag.
    logic [DW:0] mq[$];
    bit          m_ovf;
    bit          m_busy;

    ava_pixel_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .SLACK     (SLACK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .fifo_busy(fifo_busy),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b1;
    endtask

    // Advance the model by one cycle with the current inputs, then clock the DUT.
    task automatic tick();
        bit popped;
        bit was_full;
        popped   = (mq.size() > 0) && rd_ready;
        was_full = (mq.size() == DEPTH);
        if (popped) void'(mq.pop_front());
        if (wr_valid) begin
            if (!was_full || popped) mq.push_back({wr_last, wr_data});
            else m_ovf = 1'b1;
        end
        m_busy = (mq.size() >= DEPTH - SLACK);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if (fifo_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: got %b want 1", fifo_busy);
        end
        checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rd_valid=%b level=%0d overflow=%b want 0/0/0",
                     rd_valid, level, overflow);
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if (fifo_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_release: got %b want 0", fifo_busy);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || fifo_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle: rd_valid=%b level=%0d overflow=%b busy=%b want 0/0/0/0",
                     rd_valid, level, overflow, fifo_busy);
        end
    endtask

    task automatic test_single_push();
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        wr_last  = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_last !== 1'b1 || level !== 5'd1) begin
            failures++;
            $display("FAIL single_visible: valid=%b data=%h last=%b level=%0d want 1/a5/1/1",
                     rd_valid, rd_data, rd_last, level);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            failures++;
            $display("FAIL single_popped: valid=%b level=%0d want 0/0", rd_valid, level);
        end
        rd_ready = 1'b0;
    endtask

    task automatic fill_sequential();
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(i);
            wr_last  = 1'b0;
            tick();
            checks++;
            if (level !== 5'(i + 1) || fifo_busy !== (i + 1 >= 14)) begin
                failures++;
                $display("FAIL fill_%0d: level=%0d busy=%b want %0d/%b",
                         i, level, fifo_busy, i + 1, (i + 1 >= 14));
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        fill_sequential();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_head: valid=%b data=%h ovf=%b want 1/00/0",
                     rd_valid, rd_data, overflow);
        end
        wr_valid = 1'b1;
        wr_data  = 8'h10;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            failures++;
            $display("FAIL overflow_set: ovf=%b level=%0d want 1/16", overflow, level);
        end
        tick();
        tick();
        checks++;
        if (overflow !== 1'b1 || rd_data !== 8'h00 || level !== 5'd16) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%b data=%h level=%0d want 1/00/16",
                     overflow, rd_data, level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp;
        do_reset();
        fill_sequential();
        wr_valid = 1'b1;
        wr_data  = 8'h20;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (level !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h01) begin
            failures++;
            $display("FAIL full_push_pop: level=%0d ovf=%b head=%h want 16/0/01",
                     level, overflow, rd_data);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? DW'(i + 1) : 8'h20;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                failures++;
                $display("FAIL drain_%0d: valid=%b data=%h want 1/%h", i, rd_valid, rd_data, exp);
            end
            tick();
        end
        checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || fifo_busy !== 1'b0) begin
            failures++;
            $display("FAIL drained: valid=%b level=%0d busy=%b want 0/0/0",
                     rd_valid, level, fifo_busy);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            wr_last  = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (level > 5'd1 || fifo_busy !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b1
                || {rd_last, rd_data} !== mq[0]) begin
                failures++;
                $display("FAIL stream_%0d: level=%0d busy=%b ovf=%b valid=%b out=%h want %h",
                         i, level, fifo_busy, overflow, rd_valid, {rd_last, rd_data}, mq[0]);
            end
        end
        wr_valid = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            failures++;
            $display("FAIL stream_end: valid=%b level=%0d want 0/0", rd_valid, level);
        end
        rd_ready = 1'b0;
    endtask

    // Controller model: advance only when fifo_busy is low; VRAM delivers one cycle later.
    task automatic test_backpressure();
        bit advance;
        do_reset();
        advance = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            wr_valid = advance;
            wr_data  = DW'($urandom);
            wr_last  = ($urandom_range(0, 15) == 0);
            rd_ready = ($urandom_range(0, 3) == 0);
            advance  = ($urandom_range(0, 7) != 0) && !fifo_busy;
            tick();
            checks++;
            if (overflow !== 1'b0 || level !== 5'(mq.size()) || fifo_busy !== m_busy
                || rd_valid !== (mq.size() != 0)) begin
                failures++;
                $display("FAIL bp_state_%0d: ovf=%b level=%0d busy=%b valid=%b want 0/%0d/%b/%b",
                         i, overflow, level, fifo_busy, rd_valid, mq.size(), m_busy,
                         (mq.size() != 0));
            end
            if (mq.size() != 0) begin
                checks++;
                if ({rd_last, rd_data} !== mq[0]) begin
                    failures++;
                    $display("FAIL bp_data_%0d: got %h want %h", i, {rd_last, rd_data}, mq[0]);
                end
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            wr_last  = 1'b0;
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (level !== 5'd9) begin
            failures++;
            $display("FAIL pre_reset_level: got %0d want 9", level);
        end
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || fifo_busy !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: valid=%b level=%0d busy=%b want 0/0/1",
                     rd_valid, level, fifo_busy);
        end
        #2;
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        wr_last  = 1'b1;
        tick();
        wr_data = 8'h78;
        wr_last = 1'b0;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h77 || rd_last !== 1'b1 || level !== 5'd2) begin
            failures++;
            $display("FAIL post_reset_first: valid=%b data=%h last=%b level=%0d want 1/77/1/2",
                     rd_valid, rd_data, rd_last, level);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_streaming();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
